// File: rtl/cam_fb_writer_if.sv
// cam_fb_writer_if: frame-buffer write port bus (strobe, address, RGB565 data).
//   master: drives we/wAddr/wData (the camera writer)
//   slave : receives them (the frame-buffer write port)
interface cam_fb_writer_if #(
    parameter int AW = 17
);
    logic          we;
    logic [AW-1:0] wAddr;
    logic [15:0]   wData;
    modport master(output we, wAddr, wData);
    modport slave(input we, wAddr, wData);
endinterface

// File: rtl/cam_fb_writer.sv
// cam_fb_writer: captures an 8-bit RGB565 camera stream into the linear QVGA frame buffer.
//   clk, reset (async, active-low)   system clock and reset
//   capture_en                       sampled at frame start; frame is written when high
//   cam_pclk/vsync/href/data         asynchronous camera pins
//   fb (master)                      frame-buffer write port: we, wAddr = y*H_RES + x, wData
//   frame_active                     high while a frame is being captured
//   frame_done                       one-cycle pulse when a captured frame ends
module cam_fb_writer #(
    parameter int H_RES = 320,
    parameter int V_RES = 240,
    parameter int AW    = $clog2(H_RES * V_RES)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   capture_en,
    input  logic                   cam_pclk,
    input  logic                   cam_vsync,
    input  logic                   cam_href,
    input  logic [7:0]             cam_data,
    cam_fb_writer_if.master        fb,
    output logic                   frame_active,
    output logic                   frame_done
);
    localparam int XW = $clog2(H_RES + 1);
    localparam int YW = $clog2(V_RES + 1);
    localparam logic [XW-1:0] X_MAX = XW'(H_RES);
    localparam logic [YW-1:0] Y_MAX = YW'(V_RES);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;

    state_t        state;
    logic [2:0]    pclk_s, vs_s, href_s;
    logic [7:0]    data_s1, data_s2, hi;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [AW-1:0] line_base;
    logic          phase;

    logic pclk_rise, vs_rise, vs_fall, href_fall;
    assign pclk_rise = pclk_s[1] & ~pclk_s[2];
    assign vs_rise   = vs_s[1] & ~vs_s[2];
    assign vs_fall   = ~vs_s[1] & vs_s[2];
    // line end is seen in clk time, independent of pclk
    assign href_fall = ~href_s[1] & href_s[2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            pclk_s       <= '0;
            vs_s         <= '0;
            href_s       <= '0;
            data_s1      <= '0;
            data_s2      <= '0;
            hi           <= '0;
            x            <= '0;
            y            <= '0;
            line_base    <= '0;
            phase        <= 1'b0;
            fb.we        <= 1'b0;
            fb.wAddr     <= '0;
            fb.wData     <= '0;
            frame_active <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            pclk_s     <= {pclk_s[1:0], cam_pclk};
            vs_s       <= {vs_s[1:0], cam_vsync};
            href_s     <= {href_s[1:0], cam_href};
            data_s1    <= cam_data;
            data_s2    <= data_s1;
            fb.we      <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: if (vs_rise) state <= ARMED;
                ARMED: begin
                    if (vs_fall && capture_en) begin
                        state        <= CAPTURE;
                        frame_active <= 1'b1;
                        x            <= '0;
                        y            <= '0;
                        line_base    <= '0;
                        phase        <= 1'b0;
                    end
                end
                CAPTURE: begin
                    // vsync wins over any pixel completing in the same cycle
                    if (vs_rise) begin
                        state        <= IDLE;
                        frame_active <= 1'b0;
                        frame_done   <= 1'b1;
                    end else if (href_fall) begin
                        if (x != '0 && y != Y_MAX) begin
                            y         <= y + 1'b1;
                            line_base <= line_base + AW'(H_RES);
                        end
                        x     <= '0;
                        phase <= 1'b0;
                    end else if (pclk_rise && href_s[1]) begin
                        if (!phase) begin
                            hi    <= data_s2;
                            phase <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            if (x < X_MAX && y < Y_MAX) begin
                                fb.we    <= 1'b1;
                                fb.wAddr <= line_base + AW'(x);
                                fb.wData <= {hi, data_s2};
                            end
                            if (x != X_MAX) x <= x + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cam_fb_writer.sv
// tb_cam_fb_writer: directed bench for cam_fb_writer with a 4x3 frame buffer.
module tb_cam_fb_writer;
    localparam int H = 4;
    localparam int V = 3;
    localparam int AW = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       capture_en = 1'b1;
    logic       cam_pclk = 1'b0;
    logic       cam_vsync = 1'b0;
    logic       cam_href = 1'b0;
    logic [7:0] cam_data = 8'h00;
    logic       frame_active, frame_done;

    cam_fb_writer_if #(.AW(AW)) fb ();

    cam_fb_writer #(.H_RES(H), .V_RES(V), .AW(AW)) dut (
        .clk(clk), .reset(reset), .capture_en(capture_en),
        .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
        .fb(fb), .frame_active(frame_active), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    logic [AW-1:0] addr_log[$];
    logic [15:0]   data_log[$];
    int            done_cnt = 0;
    int            passed = 0;
    int            total = 0;

    // write/done recorder, sampled on the falling edge
    always @(negedge clk) begin
        if (fb.we) begin
            addr_log.push_back(fb.wAddr);
            data_log.push_back(fb.wData);
        end
        if (frame_done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        cam_data = b;
        #40 cam_pclk = 1'b1;
        #40 cam_pclk = 1'b0;
    endtask

    task automatic send_line(input int n, input logic [7:0] base);
        cam_href = 1'b1;
        #40;
        for (int i = 0; i < n; i++) send_byte(base + 8'(i));
        #40 cam_href = 1'b0;
        #200;
    endtask

    task automatic vs_pulse();
        cam_vsync = 1'b1;
        #200 cam_vsync = 1'b0;
        #200;
    endtask

    task automatic clear_logs();
        addr_log.delete();
        data_log.delete();
    endtask

    initial begin
        int d0;
        logic [AW-1:0] amax;
        #23;
        chk("reset_we", 32'(fb.we), 0);
        chk("reset_addr", 32'(fb.wAddr), 0);
        chk("reset_data", 32'(fb.wData), 0);
        chk("reset_active", 32'(frame_active), 0);
        chk("reset_done", 32'(frame_done), 0);
        reset = 1'b1;
        #40;

        // normal frame
        vs_pulse();
        chk("n_active_on", 32'(frame_active), 1);
        send_line(8, 8'h00);
        send_line(8, 8'h08);
        send_line(8, 8'h10);
        cam_vsync = 1'b1;
        #200;
        chk("n_done", 32'(done_cnt), 1);
        chk("n_active_off", 32'(frame_active), 0);
        chk("n_count", 32'(addr_log.size()), 12);
        chk("n_addr0", 32'(addr_log[0]), 0);
        chk("n_data0", 32'(data_log[0]), 32'h0001);
        chk("n_addr4", 32'(addr_log[4]), 4);
        chk("n_data4", 32'(data_log[4]), 32'h0809);
        chk("n_addr11", 32'(addr_log[11]), 11);
        chk("n_data11", 32'(data_log[11]), 32'h1617);
        chk("n_hold_addr", 32'(fb.wAddr), 11);
        chk("n_hold_data", 32'(fb.wData), 32'h1617);
        cam_vsync = 1'b0;
        #200;

        // overlong frame
        clear_logs();
        vs_pulse();
        for (int l = 0; l < 4; l++) send_line(12, 8'(l * 16));
        vs_pulse();
        chk("o_count", 32'(addr_log.size()), 12);
        amax = '0;
        foreach (addr_log[i]) if (addr_log[i] > amax) amax = addr_log[i];
        chk("o_addr_max", 32'(amax), 11);
        chk("o_addr3", 32'(addr_log[3]), 3);
        chk("o_data3", 32'(data_log[3]), 32'h0607);
        chk("o_data11", 32'(data_log[11]), 32'h2627);
        chk("o_done", 32'(done_cnt), 2);

        // odd byte line
        clear_logs();
        vs_pulse();
        send_line(5, 8'h40);
        send_line(8, 8'h50);
        vs_pulse();
        chk("odd_count", 32'(addr_log.size()), 6);
        chk("odd_addr1", 32'(addr_log[1]), 1);
        chk("odd_data1", 32'(data_log[1]), 32'h4243);
        chk("odd_addr2", 32'(addr_log[2]), 4);
        chk("odd_data2", 32'(data_log[2]), 32'h5051);
        chk("odd_addr5", 32'(addr_log[5]), 7);

        // capture_en low at frame start
        clear_logs();
        capture_en = 1'b0;
        vs_pulse();
        chk("ce_active_off", 32'(frame_active), 0);
        cam_href = 1'b1;
        #40;
        send_byte(8'h11);
        capture_en = 1'b1;
        send_byte(8'h12);
        #40 cam_href = 1'b0;
        #200;
        send_line(8, 8'h20);
        chk("ce_no_writes", 32'(addr_log.size()), 0);
        chk("ce_active_still_off", 32'(frame_active), 0);
        vs_pulse();
        chk("ce_next_active", 32'(frame_active), 1);
        send_line(8, 8'h60);
        chk("ce_next_count", 32'(addr_log.size()), 4);
        chk("ce_next_data0", 32'(data_log[0]), 32'h6061);
        vs_pulse();

        // reset mid-frame
        clear_logs();
        vs_pulse();
        send_line(8, 8'h00);
        cam_href = 1'b1;
        #40;
        send_byte(8'hA0);
        send_byte(8'hA1);
        send_byte(8'hA2);
        reset = 1'b0;
        #1;
        chk("r_we", 32'(fb.we), 0);
        chk("r_addr", 32'(fb.wAddr), 0);
        chk("r_data", 32'(fb.wData), 0);
        chk("r_active", 32'(frame_active), 0);
        #50 reset = 1'b1;
        send_byte(8'hA3);
        send_byte(8'hA4);
        send_byte(8'hA5);
        #40 cam_href = 1'b0;
        #200;
        send_line(8, 8'h30);
        chk("r_count_before", 32'(addr_log.size()), 5);
        vs_pulse();
        send_line(4, 8'h70);
        chk("r_count_after", 32'(addr_log.size()), 7);
        chk("r_addr_restart", 32'(addr_log[5]), 0);
        chk("r_data_restart", 32'(data_log[5]), 32'h7071);
        chk("r_addr_second", 32'(addr_log[6]), 1);
        vs_pulse();

        // early vsync mid-line
        clear_logs();
        vs_pulse();
        send_line(8, 8'h80);
        d0 = done_cnt;
        cam_href = 1'b1;
        #40;
        send_byte(8'h90);
        cam_vsync = 1'b1;
        #40;
        send_byte(8'h91);
        #160;
        chk("e_done", 32'(done_cnt - d0), 1);
        chk("e_active_off", 32'(frame_active), 0);
        chk("e_count", 32'(addr_log.size()), 4);
        send_byte(8'h92);
        send_byte(8'h93);
        #40 cam_href = 1'b0;
        cam_vsync = 1'b0;
        #200;
        send_line(8, 8'hB0);
        chk("e_no_more_writes", 32'(addr_log.size()), 4);
        chk("e_done_once", 32'(done_cnt - d0), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
